sigdecode_seq: RTL and testbench

SIGDECODE_SEQ -- requirements
Module: sigdecode_seq

---
 rtl/abr_params_pkg.sv | 31 +++
 rtl/sigdecode_seq_wdog.sv | 33 +++
 rtl/sigdecode_seq.sv | 149 ++++++++++++++
 tb/tb_sigdecode_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/abr_params_pkg.sv
// Shared memory-interface types, address width and sequencer state encoding
// used by the signature-decode sequencer and its sub-units.
package abr_params_pkg;

  localparam int ABR_MEM_ADDR_WIDTH = 15;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_READ  = 2'b01,
    RW_WRITE = 2'b10
  } mem_rw_mode_e;

  typedef struct packed {
    mem_rw_mode_e                  rd_wr_en;
    logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
  } mem_if_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    Z_RUN = 2'b01,
    H_RUN = 2'b10,
    DONE  = 2'b11
  } sigdecode_seq_state_e;

  localparam mem_if_t MEM_IF_IDLE = '{rd_wr_en: RW_IDLE, addr: {ABR_MEM_ADDR_WIDTH{1'b0}}};

  function automatic logic mem_req_active(input mem_if_t req);
    return (req.rd_wr_en != RW_IDLE);
  endfunction

endpackage

// File: rtl/sigdecode_seq_wdog.sv
// Clearable up-counter that flags expiry once a sub-unit run has lasted
// WDOG_CYCLES-1 counted cycles; it saturates there until cleared.
module sigdecode_seq_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_expired;

  assign w_expired = (r_count == LIMIT);
  assign o_expired = w_expired;

  // cycle counter, restarted on every run entry
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= {CNT_W{1'b0}};
    end else if (i_en && !w_expired) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/sigdecode_seq.sv
// Signature-decode sequencer: launches the z decoder then the h decoder,
// muxes their write ports onto one registered port and supervises errors.
module sigdecode_seq
  import abr_params_pkg::*;
#(
  parameter int REG_SIZE    = 24,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          zeroize,
  input  logic                          start_i,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] z_base_addr_i,
  input  logic [ABR_MEM_ADDR_WIDTH-1:0] h_base_addr_i,
  output logic                          z_enable_o,
  output logic                          h_enable_o,
  output logic [ABR_MEM_ADDR_WIDTH-1:0] z_base_addr_o,
  output logic [ABR_MEM_ADDR_WIDTH-1:0] h_base_addr_o,
  input  logic                          z_done_i,
  input  logic                          h_done_i,
  input  logic                          z_error_i,
  input  logic                          h_error_i,
  input  mem_if_t                       z_mem_wr_req_i,
  input  mem_if_t                       h_mem_wr_req_i,
  input  logic [4*REG_SIZE-1:0]         z_mem_wr_data_i,
  input  logic [4*REG_SIZE-1:0]         h_mem_wr_data_i,
  output mem_if_t                       mem_wr_req_o,
  output logic [4*REG_SIZE-1:0]         mem_wr_data_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o
);

  sigdecode_seq_state_e  r_state;
  sigdecode_seq_state_e  w_next;
  logic                  w_clr;
  logic                  w_start_acc;
  logic                  w_abort;
  logic                  w_wdog_clear;
  logic                  w_wdog_en;
  logic                  w_wdog_expired;
  mem_if_t               w_wr_req;
  logic [4*REG_SIZE-1:0] w_wr_data;

  assign w_clr        = reset | zeroize;
  assign w_wdog_en    = (r_state == Z_RUN) || (r_state == H_RUN);
  assign w_wdog_clear = ((w_next == Z_RUN) || (w_next == H_RUN)) && (w_next != r_state);

  sigdecode_seq_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .i_clk     (clk),
    .i_reset   (w_clr),
    .i_clear   (w_wdog_clear),
    .i_en      (w_wdog_en),
    .o_expired (w_wdog_expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state, abort detection and write-port selection
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_abort     = 1'b0;
    w_wr_req    = MEM_IF_IDLE;
    w_wr_data   = {(4*REG_SIZE){1'b0}};
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next      = Z_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      Z_RUN: begin
        w_wr_req  = z_mem_wr_req_i;
        w_wr_data = z_mem_wr_data_i;
        // an error beats a simultaneous done; a done beats a simultaneous expiry
        if (z_error_i || mem_req_active(h_mem_wr_req_i) || (w_wdog_expired && !z_done_i)) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else if (z_done_i) begin
          w_next = H_RUN;
        end else begin
          w_next = Z_RUN;
        end
      end
      H_RUN: begin
        w_wr_req  = h_mem_wr_req_i;
        w_wr_data = h_mem_wr_data_i;
        if (h_error_i || mem_req_active(z_mem_wr_req_i) || (w_wdog_expired && !h_done_i)) begin
          w_next  = DONE;
          w_abort = 1'b1;
        end else if (h_done_i) begin
          w_next = DONE;
        end else begin
          w_next = H_RUN;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // registered outputs, derived from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (w_clr) begin
      z_enable_o    <= 1'b0;
      h_enable_o    <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
      z_base_addr_o <= {ABR_MEM_ADDR_WIDTH{1'b0}};
      h_base_addr_o <= {ABR_MEM_ADDR_WIDTH{1'b0}};
      mem_wr_req_o  <= MEM_IF_IDLE;
      mem_wr_data_o <= {(4*REG_SIZE){1'b0}};
    end else begin
      z_enable_o    <= (w_next == Z_RUN) && (r_state != Z_RUN);
      h_enable_o    <= (w_next == H_RUN) && (r_state != H_RUN);
      busy_o        <= (w_next != IDLE);
      done_o        <= (w_next == DONE);
      mem_wr_req_o  <= w_wr_req;
      mem_wr_data_o <= w_wr_data;
      if (w_start_acc) begin
        error_o       <= 1'b0;
        z_base_addr_o <= z_base_addr_i;
        h_base_addr_o <= h_base_addr_i;
      end else begin
        error_o       <= error_o | w_abort;
        z_base_addr_o <= z_base_addr_o;
        h_base_addr_o <= h_base_addr_o;
      end
    end
  end

endmodule

// File: tb/tb_sigdecode_seq.sv
// Directed bench for sigdecode_seq: a default instance plus a short-watchdog
// instance sharing the same stimulus.
module tb_sigdecode_seq;
  import abr_params_pkg::*;

  localparam int RS = 24;
  localparam int AW = ABR_MEM_ADDR_WIDTH;

  logic clk = 1'b0;
  logic reset, zeroize, start_i;
  logic [AW-1:0] z_base_addr_i, h_base_addr_i;
  logic z_done_i, h_done_i, z_error_i, h_error_i;
  mem_if_t z_req, h_req;
  logic [4*RS-1:0] z_data, h_data;

  logic z_enable_o, h_enable_o, busy_o, done_o, error_o;
  logic [AW-1:0] z_base_addr_o, h_base_addr_o;
  mem_if_t mem_wr_req_o;
  logic [4*RS-1:0] mem_wr_data_o;

  logic wd_z_enable_o, wd_h_enable_o, wd_busy_o, wd_done_o, wd_error_o;
  logic [AW-1:0] wd_z_base_addr_o, wd_h_base_addr_o;
  mem_if_t wd_mem_wr_req_o;
  logic [4*RS-1:0] wd_mem_wr_data_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_wd_h  = 0;

  always #5 clk = ~clk;

  sigdecode_seq u_dut (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .z_base_addr_i(z_base_addr_i), .h_base_addr_i(h_base_addr_i),
    .z_enable_o(z_enable_o), .h_enable_o(h_enable_o),
    .z_base_addr_o(z_base_addr_o), .h_base_addr_o(h_base_addr_o),
    .z_done_i(z_done_i), .h_done_i(h_done_i), .z_error_i(z_error_i), .h_error_i(h_error_i),
    .z_mem_wr_req_i(z_req), .h_mem_wr_req_i(h_req),
    .z_mem_wr_data_i(z_data), .h_mem_wr_data_i(h_data),
    .mem_wr_req_o(mem_wr_req_o), .mem_wr_data_o(mem_wr_data_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  sigdecode_seq #(.REG_SIZE(RS), .WDOG_CYCLES(16)) u_wd (
    .clk(clk), .reset(reset), .zeroize(zeroize), .start_i(start_i),
    .z_base_addr_i(z_base_addr_i), .h_base_addr_i(h_base_addr_i),
    .z_enable_o(wd_z_enable_o), .h_enable_o(wd_h_enable_o),
    .z_base_addr_o(wd_z_base_addr_o), .h_base_addr_o(wd_h_base_addr_o),
    .z_done_i(z_done_i), .h_done_i(h_done_i), .z_error_i(z_error_i), .h_error_i(h_error_i),
    .z_mem_wr_req_i(z_req), .h_mem_wr_req_i(h_req),
    .z_mem_wr_data_i(z_data), .h_mem_wr_data_i(h_data),
    .mem_wr_req_o(wd_mem_wr_req_o), .mem_wr_data_o(wd_mem_wr_data_o),
    .busy_o(wd_busy_o), .done_o(wd_done_o), .error_o(wd_error_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (done_o) n_done++;
    if (wd_h_enable_o) n_wd_h++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic begin_test();
    reset = 1'b1; zeroize = 1'b0; start_i = 1'b0;
    z_done_i = 1'b0; h_done_i = 1'b0; z_error_i = 1'b0; h_error_i = 1'b0;
    z_req = MEM_IF_IDLE; h_req = MEM_IF_IDLE; z_data = '0; h_data = '0;
    z_base_addr_i = '0; h_base_addr_i = '0;
    step();
    reset = 1'b0;
    cyc = 0; n_done = 0; n_wd_h = 0;
  endtask

  initial begin
    begin_test();
    step(); step();
    begin_test();
    chk("rst_busy",  busy_o, 1'b0);
    chk("rst_done",  done_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_zen",   z_enable_o, 1'b0);
    chk("rst_hen",   h_enable_o, 1'b0);
    chk("rst_rw",    mem_wr_req_o.rd_wr_en, RW_IDLE);
    chk("rst_zbase", z_base_addr_o, 15'h0);

    // nominal run
    start_i = 1'b1; z_base_addr_i = 15'h123; h_base_addr_i = 15'h456;
    run_to(1); start_i = 1'b0;
    chk("nom_zen1",  z_enable_o, 1'b1);
    chk("nom_hen1",  h_enable_o, 1'b0);
    chk("nom_busy1", busy_o, 1'b1);
    chk("nom_zbase", z_base_addr_o, 15'h123);
    chk("nom_hbase", h_base_addr_o, 15'h456);
    run_to(2);
    chk("nom_zen2", z_enable_o, 1'b0);
    run_to(10); z_done_i = 1'b1;
    run_to(11); z_done_i = 1'b0;
    chk("nom_hen11", h_enable_o, 1'b1);
    run_to(12);
    chk("nom_hen12", h_enable_o, 1'b0);
    run_to(40); h_done_i = 1'b1;
    chk("nom_done40", done_o, 1'b0);
    run_to(41); h_done_i = 1'b0;
    chk("nom_done41", done_o, 1'b1);
    chk("nom_err41",  error_o, 1'b0);
    chk("nom_busy41", busy_o, 1'b1);
    run_to(42);
    chk("nom_done42", done_o, 1'b0);
    chk("nom_busy42", busy_o, 1'b0);
    chk("nom_ndone",  n_done, 1);

    // error and done together in H_RUN, then zeroize
    begin_test();
    start_i = 1'b1;
    run_to(1); start_i = 1'b0;
    run_to(10); z_done_i = 1'b1;
    run_to(11); z_done_i = 1'b0;
    run_to(20); h_error_i = 1'b1; h_done_i = 1'b1;
    run_to(21); h_error_i = 1'b0; h_done_i = 1'b0;
    chk("err_done21", done_o, 1'b1);
    chk("err_err21",  error_o, 1'b1);
    run_to(25);
    chk("err_hold25", error_o, 1'b1);
    chk("err_busy25", busy_o, 1'b0);
    start_i = 1'b1;
    run_to(26); start_i = 1'b0;
    chk("err_clr26",  error_o, 1'b0);
    chk("err_busy26", busy_o, 1'b1);
    zeroize = 1'b1;
    run_to(27); zeroize = 1'b0;
    chk("zer_busy", busy_o, 1'b0);
    chk("zer_zen",  z_enable_o, 1'b0);

    // watchdog expiry on the 16-cycle instance
    begin_test();
    start_i = 1'b1;
    run_to(1); start_i = 1'b0;
    run_to(16);
    chk("wd_err16",  wd_error_o, 1'b0);
    chk("wd_done16", wd_done_o, 1'b0);
    chk("wd_busy16", wd_busy_o, 1'b1);
    run_to(17);
    chk("wd_err17",  wd_error_o, 1'b1);
    chk("wd_done17", wd_done_o, 1'b1);
    run_to(20);
    chk("wd_no_hen", n_wd_h, 0);
    chk("wd_def_busy", busy_o, 1'b1);

    // write mux: legal z write forwarded, stray h write rejected
    begin_test();
    start_i = 1'b1;
    run_to(1); start_i = 1'b0;
    z_req = '{rd_wr_en: RW_WRITE, addr: 15'h10}; z_data = 96'hABC;
    run_to(2); z_req = MEM_IF_IDLE; z_data = '0;
    chk("wr_z_rw",   mem_wr_req_o.rd_wr_en, RW_WRITE);
    chk("wr_z_addr", mem_wr_req_o.addr, 15'h10);
    chk("wr_z_data", mem_wr_data_o, 96'hABC);
    chk("wr_z_err",  error_o, 1'b0);
    run_to(3); h_req = '{rd_wr_en: RW_WRITE, addr: 15'h40}; h_data = 96'h55;
    run_to(4); h_req = MEM_IF_IDLE; h_data = '0;
    chk("wr_h_rw",   mem_wr_req_o.rd_wr_en, RW_IDLE);
    chk("wr_h_addr", mem_wr_req_o.addr, 15'h0);
    chk("wr_h_err",  error_o, 1'b1);
    chk("wr_h_done", done_o, 1'b1);
    run_to(5);
    chk("wr_h_rw5",  mem_wr_req_o.rd_wr_en, RW_IDLE);

    // reset in the middle of H_RUN with a write in flight
    begin_test();
    start_i = 1'b1; z_base_addr_i = 15'h77; h_base_addr_i = 15'h99;
    run_to(1); start_i = 1'b0;
    run_to(3); z_done_i = 1'b1;
    run_to(4); z_done_i = 1'b0;
    chk("mr_hen4", h_enable_o, 1'b1);
    run_to(6); h_req = '{rd_wr_en: RW_WRITE, addr: 15'h22}; reset = 1'b1;
    run_to(7); h_req = MEM_IF_IDLE; reset = 1'b0;
    chk("mr_busy",  busy_o, 1'b0);
    chk("mr_rw",    mem_wr_req_o.rd_wr_en, RW_IDLE);
    chk("mr_done",  done_o, 1'b0);
    chk("mr_hbase", h_base_addr_o, 15'h0);
    run_to(9); start_i = 1'b1; z_base_addr_i = 15'h31;
    run_to(10); start_i = 1'b0;
    chk("mr_zen",   z_enable_o, 1'b1);
    chk("mr_busy2", busy_o, 1'b1);
    chk("mr_zbase", z_base_addr_o, 15'h31);
    chk("mr_ndone", n_done, 0);

    // start in H_RUN ignored
    begin_test();
    start_i = 1'b1; z_base_addr_i = 15'h111; h_base_addr_i = 15'h222;
    run_to(1); start_i = 1'b0;
    run_to(2); z_done_i = 1'b1;
    run_to(3); z_done_i = 1'b0;
    run_to(5); start_i = 1'b1; z_base_addr_i = 15'h333; h_base_addr_i = 15'h444;
    run_to(6); start_i = 1'b0;
    chk("ig_zbase", z_base_addr_o, 15'h111);
    chk("ig_hbase", h_base_addr_o, 15'h222);
    chk("ig_zen",   z_enable_o, 1'b0);
    run_to(8); h_done_i = 1'b1;
    run_to(9); h_done_i = 1'b0;
    chk("ig_done9", done_o, 1'b1);
    run_to(12);
    chk("ig_busy12", busy_o, 1'b0);
    chk("ig_ndone",  n_done, 1);

    // done asserted in its own launch cycle
    begin_test();
    start_i = 1'b1;
    run_to(1); start_i = 1'b0; z_done_i = 1'b1;
    run_to(2); z_done_i = 1'b0;
    chk("ln_hen2", h_enable_o, 1'b1);
    h_done_i = 1'b1;
    run_to(3); h_done_i = 1'b0;
    chk("ln_done3", done_o, 1'b1);
    chk("ln_err3",  error_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
